spi_regbank: RTL and testbench

Addressed SPI configuration register bank, the successor to the flat shift-register configuration block. A command byte selects read or write and a start address. Data words then stream in or out with address auto-increment. The bank holds NREG registers of REG_W bits; registers flagged read-only return live status inputs. It sits between the external SPI pins and the FM transmitter datapath (NCO increment, deviation, DAC enables, dither, mode flags).

---
 rtl/spi_regbank.sv | 166 ++++++++++++++++
 tb/tb_spi_regbank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank.sv
// spi_regbank: addressed SPI (mode 0) configuration register bank.
// A command byte selects read/write and a start address. Data words then stream
// in or out, and the address auto-increments after each word.
// Read-only slots return live sta_in values and are never written.
module spi_regbank #(
   parameter int unsigned             ADDR_W    = 4,
   parameter int unsigned             REG_W     = 8,
   parameter int unsigned             NREG      = 8,
   parameter logic [NREG*REG_W-1:0]   RESET_VAL = '0,
   parameter logic [NREG-1:0]         RO_MASK   = '0
) (
   input  logic                   spi_clk,
   input  logic                   rst,
   input  logic                   spi_csn,
   input  logic                   spi_mosi,
   output logic                   spi_miso,
   input  logic [NREG*REG_W-1:0]  sta_in,
   output logic [NREG*REG_W-1:0]  cfg_out,
   output logic                   wr_strobe,
   output logic [ADDR_W-1:0]      wr_addr
);

   localparam int unsigned NADDR = 1 << ADDR_W;
   localparam int unsigned CNT_W = $clog2(REG_W > 8 ? REG_W : 8);

   typedef enum logic {StCmd, StData} phase_e;

   phase_e                         phase_q, phase_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [6:0]                     cmd_q, cmd_d;
   logic [ADDR_W-1:0]              addr_q, addr_d;
   logic                           rw_q, rw_d;
   logic [REG_W-2:0]               data_q, data_d;
   logic [REG_W-1:0]               rd_q, rd_d;

   logic                           frame_rst;
   logic [7:0]                     cmd_full;
   logic [REG_W-1:0]               word_in;
   logic [ADDR_W-1:0]              addr_inc;
   logic                           commit;
   logic                           wr_hit;
   logic [NADDR-1:0][REG_W-1:0]    rd_tab;
   logic [NADDR-1:0]               wr_ok;
   logic                           unused_sta;

   // Frame state is discarded whenever the chip is deselected.
   assign frame_rst = rst | spi_csn;
   assign cmd_full  = {cmd_q, spi_mosi};
   assign word_in   = {data_q, spi_mosi};
   assign addr_inc  = addr_q + ADDR_W'(1);
   assign wr_hit    = commit & wr_ok[addr_q];
   // Non-RO slots of sta_in are intentionally ignored.
   assign unused_sta = ^sta_in;

   // Full address map: implemented RW, implemented RO, and unimplemented (reads 0).
   for (genvar g = 0; g < NADDR; g++) begin : g_addr
      if (g < NREG) begin : g_impl
         logic [REG_W-1:0] q;
         if (RO_MASK[g]) begin : g_ro
            assign q         = '0;
            assign rd_tab[g] = sta_in[g*REG_W +: REG_W];
            assign wr_ok[g]  = 1'b0;
         end else begin : g_rw
            // Register storage; only rst clears it, only a committed word updates it.
            always_ff @(posedge spi_clk or posedge rst) begin
               if (rst) begin
                  q <= RESET_VAL[g*REG_W +: REG_W];
               end else if (wr_hit && (addr_q == ADDR_W'(g))) begin
                  q <= word_in;
               end
            end
            assign rd_tab[g] = q;
            assign wr_ok[g]  = 1'b1;
         end
         assign cfg_out[g*REG_W +: REG_W] = q;
      end else begin : g_unimpl
         assign rd_tab[g] = '0;
         assign wr_ok[g]  = 1'b0;
      end
   end

   // Frame state register, cleared by rst or a deselect.
   always_ff @(posedge spi_clk or posedge frame_rst) begin
      if (frame_rst) begin
         phase_q <= StCmd;
         cnt_q   <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         data_q  <= '0;
         rd_q    <= '0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
      end
   end

   // Next-state: command decode, word counting, commit and read reload.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      data_d  = data_q;
      rd_d    = rd_q;
      commit  = 1'b0;
      unique case (phase_q)
         StCmd: begin
            cmd_d = cmd_full[6:0];
            if (cnt_q == CNT_W'(7)) begin
               phase_d = StData;
               cnt_d   = '0;
               rw_d    = cmd_full[7];
               addr_d  = cmd_full[ADDR_W-1:0];
               rd_d    = cmd_full[7] ? rd_tab[cmd_full[ADDR_W-1:0]] : '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StData: begin
            data_d = word_in[REG_W-2:0];
            rd_d   = {rd_q[REG_W-2:0], 1'b0};
            if (cnt_q == CNT_W'(REG_W - 1)) begin
               cnt_d  = '0;
               addr_d = addr_inc;
               commit = ~rw_q;
               if (rw_q) begin
                  rd_d = rd_tab[addr_inc];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Write strobe and address; deliberately not cleared by CSn so a final strobe completes.
   always_ff @(posedge spi_clk or posedge rst) begin
      if (rst) begin
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
      end else begin
         wr_strobe <= wr_hit;
         if (wr_hit) begin
            wr_addr <= addr_q;
         end
      end
   end

   // MISO launches on the falling edge so the master samples it on the next rising edge.
   always_ff @(negedge spi_clk or posedge frame_rst) begin
      if (frame_rst) begin
         spi_miso <= 1'b0;
      end else begin
         spi_miso <= ((phase_q == StData) && rw_q) ? rd_q[REG_W-1] : 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: directed and randomized SPI frames against a behavioural register model.
module tb_spi_regbank;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned REG_W  = 8;
   localparam int unsigned NREG   = 8;
   localparam logic [63:0] RST_V  = 64'h0000_0000_0000_0102;
   localparam logic [7:0]  RO_M   = 8'b0010_0000;

   logic        spi_clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_csn = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [63:0] sta_vec = '0;
   logic [63:0] cfg_out;
   logic        wr_strobe;
   logic [3:0]  wr_addr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [NREG];
   bit         ro [NREG];
   logic [7:0] tx_words [8];

   spi_regbank #(
      .ADDR_W    (ADDR_W),
      .REG_W     (REG_W),
      .NREG      (NREG),
      .RESET_VAL (RST_V),
      .RO_MASK   (RO_M)
   ) dut (
      .spi_clk   (spi_clk),
      .rst       (rst),
      .spi_csn   (spi_csn),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .sta_in    (sta_vec),
      .cfg_out   (cfg_out),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr)
   );

   always #5 spi_clk = ~spi_clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < NREG; i++) begin
         ro[i]  = RO_M[i];
         mem[i] = ro[i] ? 8'h00 : RST_V[i*8 +: 8];
      end
   endtask

   function automatic logic [63:0] model_cfg();
      logic [63:0] r;
      for (int i = 0; i < NREG; i++) r[i*8 +: 8] = ro[i] ? 8'h00 : mem[i];
      return r;
   endfunction

   function automatic logic [7:0] exp_rd(input int a);
      if (a >= NREG) return 8'h00;
      if (ro[a]) return sta_vec[a*8 +: 8];
      return mem[a];
   endfunction

   // One frame of nbits clocks: cmd byte then tx_words, MSB first.
   task automatic run_frame(input logic [7:0] cmd, input int nbits, input bit keep_cs);
      logic       ms, b;
      logic [7:0] rx;
      int         k, w, a, stray;
      bit         hit, last_hit;
      stray = 0;
      rx = '0;
      last_hit = 0;
      for (int i = 0; i < nbits; i++) begin
         k = i - 8;
         w = (k >= 0) ? k / 8 : 0;
         if (i < 8) b = cmd[7-i];
         else b = tx_words[w][7-(k%8)];
         @(negedge spi_clk); #1;
         ms = spi_miso;
         spi_mosi = b;
         spi_csn = 1'b0;
         @(posedge spi_clk); #1;
         a = (int'(cmd[3:0]) + w) % 16;
         if (i >= 8 && cmd[7]) begin
            rx = {rx[6:0], ms};
            if (k % 8 == 7) check_eq("rd_word", rx, exp_rd(a));
         end else if (ms !== 1'b0) begin
            stray++;
         end
         last_hit = 0;
         if (i >= 8 && !cmd[7] && (k % 8 == 7)) begin
            hit = (a < NREG) && !ro[a];
            if (hit) begin
               mem[a] = tx_words[w];
               check_eq("wr_addr", wr_addr, a);
            end
            check_eq("wr_strobe", wr_strobe, hit);
            check_eq("cfg_commit", cfg_out, model_cfg());
            last_hit = hit;
         end else if (wr_strobe !== 1'b0) begin
            stray++;
         end
      end
      if (!keep_cs) begin
         @(negedge spi_clk); #1;
         spi_csn = 1'b1;
         spi_mosi = 1'b0;
         #1;
         check_eq("miso_idle", spi_miso, 0);
         if (last_hit) check_eq("stb_hold", wr_strobe, 1);
         @(posedge spi_clk); #1;
         check_eq("stb_clr", wr_strobe, 0);
         check_eq("cfg_end", cfg_out, model_cfg());
      end
      check_eq("stray", stray, 0);
   endtask

   initial begin
      logic [7:0] cmd;
      int nw, extra;
      reset_model();
      repeat (3) @(posedge spi_clk);
      #1;
      check_eq("rst_cfg", cfg_out, 64'h0102);
      check_eq("rst_miso", spi_miso, 0);
      check_eq("rst_stb", wr_strobe, 0);
      check_eq("rst_waddr", wr_addr, 0);
      rst = 1'b0;

      tx_words[0] = 8'hA5;
      run_frame(8'h03, 16, 0);
      check_eq("reg3", cfg_out[31:24], 8'hA5);

      tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33;
      run_frame(8'h06, 32, 0);
      check_eq("reg67", cfg_out[63:48], 16'h2211);

      run_frame(8'h83, 16, 0);

      sta_vec[47:40] = 8'h5C;
      run_frame(8'h85, 16, 0);
      tx_words[0] = 8'hAA;
      run_frame(8'h05, 16, 0);
      check_eq("ro5", cfg_out[47:40], 8'h00);

      // Abort mid-word, then a clean rewrite.
      tx_words[0] = 8'hFF;
      run_frame(8'h02, 13, 0);
      run_frame(8'h02, 16, 0);
      check_eq("reg2", cfg_out[23:16], 8'hFF);
      // Abort mid-command.
      run_frame(8'h03, 5, 0);

      // Address wrap 15 -> 0 in both directions.
      tx_words[0] = 8'h99; tx_words[1] = 8'h3C;
      run_frame(8'h0F, 24, 0);
      check_eq("wrap_reg0", cfg_out[7:0], 8'h3C);
      run_frame(8'h8F, 24, 0);

      // Zero-length frame.
      @(negedge spi_clk); #1;
      spi_csn = 1'b0;
      #1;
      spi_csn = 1'b1;
      @(posedge spi_clk); #1;
      check_eq("zero_len", cfg_out, model_cfg());

      // Reset mid-burst with CSn held low.
      tx_words[0] = 8'hC3;
      run_frame(8'h01, 12, 1);
      rst = 1'b1;
      #1;
      reset_model();
      check_eq("midrst_cfg", cfg_out, 64'h0102);
      check_eq("midrst_miso", spi_miso, 0);
      rst = 1'b0;
      tx_words[0] = 8'h77;
      run_frame(8'h04, 16, 0);
      check_eq("post_rst", cfg_out[39:32], 8'h77);

      for (int f = 0; f < 40; f++) begin
         cmd = 8'($urandom);
         nw = $urandom_range(1, 3);
         extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         sta_vec = {$urandom, $urandom};
         for (int j = 0; j < 8; j++) tx_words[j] = 8'($urandom);
         run_frame(cmd, 8 + 8 * nw + extra, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
